pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 123 ++++++++++++
 tb/tb_pc_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with trap handling and an optional return-address stack.
// Define PC_UNIT_RAS_EN to compile in the RAS; without it ret uses ret_target.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] ret_target,
  input  logic             exception,
  input  logic             eret,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus,
  output logic [WIDTH-1:0] EPC,
  output logic             in_handler,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] HANDLER = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ret_addr;
  logic             take_eret;

  assign in_handler = (state == HANDLER);
  assign PC_plus    = PC + WIDTH'(INC);
  assign take_eret  = eret & in_handler & ~exception;

`ifdef PC_UNIT_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top;
  logic [CW-1:0]    count;
  logic             flow;
  logic             push;
  logic             pop;

  assign top       = ptr - PW'(1);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));
  assign ret_addr  = ras_empty ? ret_target : stack[top];

  // lower-priority sources only act when no trap event and no stall
  assign flow = ~exception & ~take_eret & ~stall;
  assign push = flow & jump & call;
  assign pop  = flow & ret & ~ras_empty
              & ((~jump & ~branch_taken) | push);

  // pointer/count bookkeeping; a full push overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !pop) begin
      ptr   <= ptr + PW'(1);
      count <= ras_full ? count : count + CW'(1);
    end else if (pop && !push) begin
      ptr   <= top;
      count <= count - CW'(1);
    end
  end

  // return-address storage; pop+push replaces the top entry in place
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      if (pop) stack[top] <= PC_plus;
      else     stack[ptr] <= PC_plus;
    end
  end
`else
  logic unused_call;

  assign unused_call = call;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ret_addr    = ret_target;
`endif

  // pick the next PC by priority
  always_comb begin
    pc_next = PC_plus;
    if (exception)         pc_next = EXC_VECTOR;
    else if (take_eret)    pc_next = EPC;
    else if (stall)        pc_next = PC;
    else if (jump)         pc_next = jump_target;
    else if (branch_taken) pc_next = branch_target;
    else if (ret)          pc_next = ret_addr;
  end

  // PC, saved PC and trap state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PC    <= RESET_VECTOR;
      EPC   <= '0;
      state <= NORMAL;
    end else begin
      PC <= pc_next;
      if (exception) begin
        if (state == NORMAL) EPC <= PC;
        state <= HANDLER;
      end else if (take_eret) begin
        state <= NORMAL;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed table, RAS and narrow-width
// sequences, then random traffic against a queue-based model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n, stall, branch_taken, jump, call, ret;
  logic        exception, eret;
  logic [31:0] branch_target, jump_target, ret_target;
  logic [31:0] PC, PC_plus, EPC;
  logic        in_handler, ras_empty, ras_full;
  logic [7:0]  PC8, PCp8, EPC8;
  logic        h8, e8, f8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call),
    .ret(ret), .ret_target(ret_target),
    .exception(exception), .eret(eret),
    .PC(PC), .PC_plus(PC_plus), .EPC(EPC),
    .in_handler(in_handler), .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  pc_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
    .jump(jump), .jump_target(jump_target[7:0]), .call(call),
    .ret(ret), .ret_target(ret_target[7:0]),
    .exception(exception), .eret(eret),
    .PC(PC8), .PC_plus(PCp8), .EPC(EPC8),
    .in_handler(h8), .ras_empty(e8), .ras_full(f8)
  );

  typedef struct {
    logic        rst_n, stl, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        cl, rt_en;
    logic [31:0] rt;
    logic        exc, er;
    logic [31:0] pc, epc;
    logic        h;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_h;
  logic [31:0] m_ras[$];

  function automatic vec_t v(
    logic rs, logic st, logic b, logic [31:0] bt,
    logic j, logic [31:0] jt, logic c, logic r,
    logic [31:0] rt, logic x, logic e,
    logic [31:0] pc, logic [31:0] epc, logic h);
    vec_t t;
    t.rst_n = rs; t.stl = st; t.br = b; t.bt = bt;
    t.jmp = j; t.jt = jt; t.cl = c; t.rt_en = r;
    t.rt = rt; t.exc = x; t.er = e;
    t.pc = pc; t.epc = epc; t.h = h;
    return t;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic idle();
    reset_n = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0;
    exception = 1'b0; eret = 1'b0;
    branch_target = '0; jump_target = '0; ret_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // spec-level next-state rules
  task automatic model_step();
    logic [31:0] old_pc;
    logic        do_push, do_pop;
    old_pc = m_pc;
    if (!reset_n) begin
      m_pc = 32'h0; m_epc = 32'h0; m_h = 1'b0;
      m_ras.delete();
    end else if (exception) begin
      if (!m_h) m_epc = m_pc;
      m_pc = 32'h180; m_h = 1'b1;
    end else if (eret && m_h) begin
      m_pc = m_epc; m_h = 1'b0;
    end else if (!stall) begin
`ifdef PC_UNIT_RAS_EN
      do_push = jump && call;
`else
      do_push = 1'b0;
`endif
      do_pop = ret && m_ras.size() > 0 &&
               ((!jump && !branch_taken) || do_push);
      if (jump) m_pc = jump_target;
      else if (branch_taken) m_pc = branch_target;
      else if (ret) m_pc = (m_ras.size() > 0) ? m_ras[$] : ret_target;
      else m_pc = m_pc + 32'd4;
      if (do_pop) void'(m_ras.pop_back());
      if (do_push) begin
        m_ras.push_back(old_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic chk_model(int c);
    string s;
    s = $sformatf("rand%0d", c);
    chk({s, ".pc"}, PC, m_pc);
    chk({s, ".pcp"}, PC_plus, m_pc + 32'd4);
    chk({s, ".epc"}, EPC, m_epc);
    chk({s, ".h"}, {31'b0, in_handler}, {31'b0, m_h});
    chk({s, ".emp"}, {31'b0, ras_empty},
        {31'b0, m_ras.size() == 0});
    chk({s, ".full"}, {31'b0, ras_full},
        {31'b0, m_ras.size() == 4});
  endtask

  initial begin
    logic [31:0] exp_ret[5];
    idle();

    // directed table
    tbl.push_back(v(0,0,0,0,     0,0,     0,0,0,     0,0, 32'h0,  0,     0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,0, 32'h4,  0,     0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,0, 32'h8,  0,     0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,0, 32'hc,  0,     0));
    tbl.push_back(v(1,0,0,0,     1,'h10,  0,0,0,     0,0, 32'h10, 0,     0));
    tbl.push_back(v(1,1,0,0,     1,'h200, 0,0,0,     0,0, 32'h10, 0,     0));
    tbl.push_back(v(1,0,0,0,     1,'h200, 0,0,0,     0,0, 32'h200,0,     0));
    tbl.push_back(v(1,0,0,0,     1,'h40,  0,0,0,     0,0, 32'h40, 0,     0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     1,0, 32'h180,'h40,  1));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,0, 32'h184,'h40,  1));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     1,0, 32'h180,'h40,  1));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,1, 32'h40, 'h40,  0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,1, 32'h44, 'h40,  0));
    tbl.push_back(v(1,1,0,0,     0,0,     0,0,0,     0,1, 32'h44, 'h40,  0));
    tbl.push_back(v(1,1,0,0,     0,0,     0,0,0,     1,0, 32'h180,'h44,  1));
    tbl.push_back(v(1,1,0,0,     0,0,     0,0,0,     0,1, 32'h44, 'h44,  0));
    tbl.push_back(v(1,0,1,'h300, 0,0,     0,1,'h500, 0,0, 32'h300,'h44,  0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,1,'h500, 0,0, 32'h500,'h44,  0));
    tbl.push_back(v(1,0,1,'h700, 1,'h600, 0,0,0,     0,0, 32'h600,'h44,  0));
    tbl.push_back(v(0,0,0,0,     0,0,     0,0,0,     1,0, 32'h0,  0,     0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     1,0, 32'h180,0,     1));
    tbl.push_back(v(0,0,0,0,     0,0,     0,0,0,     0,1, 32'h0,  0,     0));
    tbl.push_back(v(1,0,0,0,     0,0,     0,0,0,     0,0, 32'h4,  0,     0));

    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n; stall = tbl[i].stl;
      branch_taken = tbl[i].br; branch_target = tbl[i].bt;
      jump = tbl[i].jmp; jump_target = tbl[i].jt;
      call = tbl[i].cl; ret = tbl[i].rt_en;
      ret_target = tbl[i].rt;
      exception = tbl[i].exc; eret = tbl[i].er;
      tick();
      chk($sformatf("vec%0d.pc", i), PC, tbl[i].pc);
      chk($sformatf("vec%0d.epc", i), EPC, tbl[i].epc);
      chk($sformatf("vec%0d.h", i), {31'b0, in_handler},
          {31'b0, tbl[i].h});
    end

    // call/return sequence
    idle(); reset_n = 1'b0; tick();
    chk("ras.rst_empty", {31'b0, ras_empty}, 32'd1);
    idle();
    for (int i = 0; i < 5; i++) begin
      jump = 1'b1; call = 1'b1;
      jump_target = 32'(i + 1) * 32'h100;
      tick();
      chk($sformatf("call%0d.pc", i), PC, 32'(i + 1) * 32'h100);
    end
`ifdef PC_UNIT_RAS_EN
    chk("ras.full", {31'b0, ras_full}, 32'd1);
    exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h900};
`else
    chk("ras.full", {31'b0, ras_full}, 32'd0);
    exp_ret = '{32'h900, 32'h900, 32'h900, 32'h900, 32'h900};
`endif
    idle();
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1; ret_target = 32'h900;
      tick();
      chk($sformatf("ret%0d.pc", i), PC, exp_ret[i]);
    end
    chk("ras.empty", {31'b0, ras_empty}, 32'd1);

    // 8-bit wrap and reset out of handler
    idle(); reset_n = 1'b0; tick();
    chk("w8.rst", {24'b0, PC8}, 32'h0);
    idle(); jump = 1'b1; jump_target = 32'hfc; tick();
    chk("w8.jmp", {24'b0, PC8}, 32'hfc);
    idle(); tick();
    chk("w8.wrap", {24'b0, PC8}, 32'h0);
    idle(); exception = 1'b1; tick();
    chk("w8.exc", {24'b0, PC8}, 32'h80);
    chk("w8.h", {31'b0, h8}, 32'd1);
    idle(); reset_n = 1'b0; tick();
    chk("w8.rst2", {24'b0, PC8}, 32'h0);
    chk("w8.h2", {31'b0, h8}, 32'd0);
    chk("w8.emp", {31'b0, e8}, 32'd1);

    // random traffic against the model
    idle(); reset_n = 1'b0;
    model_step(); tick(); chk_model(0);
    for (int c = 1; c < 600; c++) begin
      reset_n      = ($urandom_range(63) != 0);
      stall        = ($urandom_range(3) == 0);
      exception    = ($urandom_range(15) == 0);
      eret         = ($urandom_range(7) == 0);
      jump         = ($urandom_range(3) == 0);
      call         = $urandom_range(1);
      branch_taken = ($urandom_range(3) == 0);
      ret          = ($urandom_range(2) == 0);
      branch_target = $urandom & ~32'h3;
      jump_target   = $urandom & ~32'h3;
      ret_target    = $urandom & ~32'h3;
      model_step();
      tick();
      chk_model(c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
